// File: rtl/t01_piece_lock.sv
// t01_piece_lock: owns the committed playfield, merges a locking piece into it,
// hands the merged board to the line clearer and commits the cleared result.
module t01_piece_lock (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [3:0]   gamestate,
  input  logic         lock_req,
  input  logic [199:0] piece_array,
  input  logic [2:0]   piece_color,
  input  logic         eval_complete,
  input  logic [199:0] cleared_array,
  input  logic [599:0] cleared_color_array,
  output logic [199:0] stack_array,
  output logic [599:0] stack_color_array,
  output logic         start_eval,
  output logic         lock_done,
  output logic         busy,
  output logic         game_over,
  output logic         eval_timeout,
  output logic [9:0]   pieces_locked
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MERGE, S_START, S_WAIT, S_DONE, S_OVER} state_t;

  state_t       r_state, w_next;
  logic [199:0] r_stack, r_piece;
  logic [599:0] r_color, w_merged_color;
  logic [2:0]   r_pcolor;
  logic [5:0]   r_wd;
  logic [9:0]   r_count;
  logic         r_start, r_done, r_over, r_timeout;
  logic         w_restart, w_commit, w_timeout;

  assign w_restart = gamestate == 4'd9;
  assign w_commit  = r_state == S_WAIT && eval_complete;
  assign w_timeout = r_state == S_WAIT && !eval_complete && &r_wd;

  for (genvar i = 0; i < 200; i++) begin : g_cell
    assign w_merged_color[3*i +: 3] = r_piece[i] ? r_pcolor : r_color[3*i +: 3];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = lock_req ? S_CHECK : S_IDLE;
      S_CHECK: w_next = |(r_piece & r_stack) ? S_OVER : S_MERGE;
      S_MERGE: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  w_next = (eval_complete || &r_wd) ? S_DONE : S_WAIT;
      S_DONE:  w_next = |r_stack[9:0] ? S_OVER : S_IDLE;
      S_OVER:  w_next = S_OVER;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_restart ? S_IDLE : w_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stack   <= '0;
      r_color   <= '0;
      r_piece   <= '0;
      r_pcolor  <= '0;
      r_wd      <= '0;
      r_count   <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_over    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_restart) begin
      r_stack   <= '0;
      r_color   <= '0;
      r_piece   <= '0;
      r_pcolor  <= '0;
      r_wd      <= '0;
      r_count   <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_over    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start <= w_next == S_START;
      r_done  <= w_next == S_DONE;
      if (r_state == S_IDLE && lock_req) begin
        r_piece  <= piece_array;
        r_pcolor <= piece_color;
      end
      if (r_state == S_MERGE) begin
        r_stack <= r_stack | r_piece;
        r_color <= w_merged_color;
      end
      if (w_commit) begin
        r_stack <= cleared_array;
        r_color <= cleared_color_array;
        r_count <= r_count + {9'd0, ~&r_count};
      end
      // watchdog restarts on every start pulse and only advances while waiting
      r_wd <= r_state == S_START ? 6'd0 : r_wd + {5'd0, r_state == S_WAIT};
      if (w_timeout) r_timeout <= 1'b1;
      if (w_next == S_OVER) r_over <= 1'b1;
    end
  end

  assign stack_array       = r_stack;
  assign stack_color_array = r_color;
  assign start_eval        = r_start;
  assign lock_done         = r_done;
  assign busy              = r_state != S_IDLE && r_state != S_OVER;
  assign game_over         = r_over;
  assign eval_timeout      = r_timeout;
  assign pieces_locked     = r_count;
endmodule

// File: tb/tb_t01_piece_lock.sv
// tb_t01_piece_lock: randomized lock sequences checked against a transaction-level
// playfield model with its own line-clear emulation.
module tb_t01_piece_lock;
  logic         clk = 1'b0, n_rst = 1'b0;
  logic [3:0]   gamestate = 4'd0;
  logic         lock_req = 1'b0, eval_complete = 1'b0;
  logic [199:0] piece_array = '0, cleared_array = '0;
  logic [2:0]   piece_color = 3'd0;
  logic [599:0] cleared_color_array = '0;
  logic [199:0] stack_array;
  logic [599:0] stack_color_array;
  logic         start_eval, lock_done, busy, game_over, eval_timeout;
  logic [9:0]   pieces_locked;

  int n_chk = 0, n_fail = 0;
  logic [199:0] m_stack, cl_in;
  logic [599:0] m_color, cl_cin;
  int           m_cnt;
  bit           m_over, m_to;

  t01_piece_lock dut (
    .clk(clk), .n_rst(n_rst), .gamestate(gamestate), .lock_req(lock_req),
    .piece_array(piece_array), .piece_color(piece_color), .eval_complete(eval_complete),
    .cleared_array(cleared_array), .cleared_color_array(cleared_color_array),
    .stack_array(stack_array), .stack_color_array(stack_color_array),
    .start_eval(start_eval), .lock_done(lock_done), .busy(busy), .game_over(game_over),
    .eval_timeout(eval_timeout), .pieces_locked(pieces_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] rnd200();
    logic [199:0] v;
    for (int i = 0; i < 200; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic m_reset;
    m_stack = '0;
    m_color = '0;
    m_cnt   = 0;
    m_over  = 1'b0;
    m_to    = 1'b0;
  endtask

  // reference line clear: full rows vanish, rows above fall toward row 19
  task automatic lclear(input logic [199:0] b, input logic [599:0] c,
                        output logic [199:0] ob, output logic [599:0] oc);
    int w;
    w  = 19;
    ob = '0;
    oc = '0;
    for (int r = 19; r >= 0; r--)
      if (b[r*10 +: 10] != 10'h3ff) begin
        ob[w*10 +: 10] = b[r*10 +: 10];
        oc[w*30 +: 30] = c[r*30 +: 30];
        w--;
      end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_stack"}, 600'(stack_array), 600'(0));
    chk({tag, "_color"}, stack_color_array, 600'(0));
    chk({tag, "_flags"}, 600'({start_eval, lock_done, busy, game_over, eval_timeout}), 600'(0));
    chk({tag, "_count"}, 600'(pieces_locked), 600'(0));
  endtask

  task automatic restart;
    gamestate = 4'd9;
    tick;
    gamestate = 4'd0;
    m_reset;
    chk_idle_zero("restart");
  endtask

  task automatic lock_to_wait(input logic [199:0] p, input logic [2:0] c, output bit ov);
    ov = |(p & m_stack);
    piece_array = p;
    piece_color = c;
    lock_req = 1'b1;
    tick;
    lock_req = 1'b0;
    piece_array = rnd200();
    piece_color = 3'($urandom);
    chk("busy_check", 600'(busy), 600'(1));
    if ($urandom_range(0, 1) == 1) begin
      eval_complete = 1'b1;
      cleared_array = rnd200();
    end
    tick;
    eval_complete = 1'b0;
    if (ov) begin
      m_over = 1'b1;
      chk("ovl_over", 600'(game_over), 600'(1));
      chk("ovl_busy", 600'(busy), 600'(0));
      chk("ovl_board", 600'(stack_array), 600'(m_stack));
      chk("ovl_color", stack_color_array, m_color);
      tick;
      chk("ovl_nostart", 600'(start_eval), 600'(0));
      return;
    end
    chk("merge_nostart", 600'(start_eval), 600'(0));
    tick;
    for (int i = 0; i < 200; i++) if (p[i]) m_color[3*i +: 3] = c;
    m_stack |= p;
    chk("start_pulse", 600'(start_eval), 600'(1));
    chk("merged_board", 600'(stack_array), 600'(m_stack));
    chk("merged_color", stack_color_array, m_color);
    cl_in  = stack_array;
    cl_cin = stack_color_array;
    tick;
    chk("start_once", 600'(start_eval), 600'(0));
  endtask

  task automatic finish_lock(input int lat, input bit to, input bit topout, input bit drop);
    logic [199:0] co;
    logic [599:0] cco;
    if (to) begin
      repeat (63) tick;
      chk("wd_early", 600'(eval_timeout), 600'(0));
      chk("wd_busy", 600'(busy), 600'(1));
      tick;
      chk("wd_flag", 600'(eval_timeout), 600'(1));
      chk("wd_done", 600'(lock_done), 600'(1));
      m_to = 1'b1;
    end else begin
      for (int i = 0; i < lat; i++) begin
        if (drop && i == 0) begin
          lock_req = 1'b1;
          piece_array = rnd200();
        end
        tick;
        lock_req = 1'b0;
      end
      lclear(cl_in, cl_cin, co, cco);
      if (topout) co[$urandom_range(0, 9)] = 1'b1;
      cleared_array = co;
      cleared_color_array = cco;
      eval_complete = 1'b1;
      tick;
      eval_complete = 1'b0;
      cleared_array = rnd200();
      m_stack = co;
      m_color = cco;
      if (m_cnt < 1023) m_cnt++;
      chk("done_pulse", 600'(lock_done), 600'(1));
    end
    chk("done_board", 600'(stack_array), 600'(m_stack));
    chk("done_color", stack_color_array, m_color);
    chk("done_count", 600'(pieces_locked), 600'(m_cnt));
    chk("done_nostart", 600'(start_eval), 600'(0));
    chk("done_busy", 600'(busy), 600'(1));
    tick;
    m_over = |m_stack[9:0];
    chk("done_once", 600'(lock_done), 600'(0));
    chk("over_flag", 600'(game_over), 600'(m_over));
    chk("busy_after", 600'(busy), 600'(0));
    chk("timeout_flag", 600'(eval_timeout), 600'(m_to));
  endtask

  task automatic lock_in_over;
    lock_req = 1'b1;
    piece_array = rnd200();
    tick;
    lock_req = 1'b0;
    repeat (3) tick;
    chk("over_ignore_busy", 600'(busy), 600'(0));
    chk("over_ignore_start", 600'(start_eval), 600'(0));
    chk("over_ignore_flag", 600'(game_over), 600'(1));
    chk("over_ignore_board", 600'(stack_array), 600'(m_stack));
  endtask

  initial begin
    logic [199:0] p;
    bit ov;
    int kind;
    m_reset;
    tick;
    tick;
    chk_idle_zero("reset");
    n_rst = 1'b1;
    tick;

    p = '0;
    p[193:190] = 4'hf;
    lock_to_wait(p, 3'd5, ov);
    finish_lock(3, 1'b0, 1'b0, 1'b0);
    chk("basic_bits", 600'(stack_array[193:190]), 600'(4'hf));
    chk("basic_color", 600'(stack_color_array[3*190 +: 12]), 600'(12'o5555));

    restart;
    p = '0;
    p[150] = 1'b1;
    lock_to_wait(p, 3'd2, ov);
    finish_lock(1, 1'b0, 1'b0, 1'b0);
    p[151] = 1'b1;
    lock_to_wait(p, 3'd3, ov);
    chk("ovl_detected", 600'(ov), 600'(1));
    lock_in_over;

    restart;
    p = '0;
    p[199:196] = 4'hf;
    lock_to_wait(p, 3'd4, ov);
    finish_lock(2, 1'b0, 1'b1, 1'b0);
    chk("topout_over", 600'(game_over), 600'(1));
    lock_in_over;

    restart;
    lock_to_wait(p, 3'd6, ov);
    gamestate = 4'd9;
    tick;
    gamestate = 4'd0;
    m_reset;
    chk_idle_zero("rst_wait");
    eval_complete = 1'b1;
    cleared_array = rnd200();
    tick;
    eval_complete = 1'b0;
    tick;
    chk_idle_zero("rst_late_eval");

    lock_to_wait(p, 3'd1, ov);
    #3 n_rst = 1'b0;
    #1 chk_idle_zero("async_rst");
    tick;
    n_rst = 1'b1;
    m_reset;
    eval_complete = 1'b1;
    tick;
    eval_complete = 1'b0;
    chk_idle_zero("async_late_eval");

    p = '0;
    p[185:180] = 6'h3f;
    lock_to_wait(p, 3'd7, ov);
    finish_lock(0, 1'b1, 1'b0, 1'b0);

    restart;
    p = '0;
    p[199:190] = 10'h3ff;
    lock_to_wait(p, 3'd2, ov);
    finish_lock(4, 1'b0, 1'b0, 1'b1);
    chk("row_cleared", 600'(stack_array), 600'(0));

    for (int n = 0; n < 80; n++) begin
      if (m_over) restart;
      p = '0;
      kind = $urandom_range(0, 3);
      if (kind == 3) p[$urandom_range(14, 19)*10 +: 10] = 10'h3ff;
      else if (kind != 0) repeat (4) p[$urandom_range(120, 199)] = 1'b1;
      lock_to_wait(p, 3'($urandom_range(1, 7)), ov);
      if (!ov)
        finish_lock($urandom_range(0, 5), $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    restart;
    repeat (1030) begin
      lock_to_wait('0, 3'($urandom_range(1, 7)), ov);
      finish_lock(0, 1'b0, 1'b0, 1'b0);
    end
    chk("saturate", 600'(pieces_locked), 600'(1023));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
